// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, ERR} fetch_state_t;
  localparam logic [1:0] FETCH_ALIGN_MASK = 2'b11;
endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding instruction-memory read, a single-entry buffer
// toward decode, and pc_en pulses back to the program counter.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  output logic            pc_en,
  input  logic            flush,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  output logic            misaligned,
  output logic [31:0]     fetch_count
);

  fetch_state_t    state, next_state;
  logic            drop, drop_next;
  logic [XLEN-1:0] req_pc;
  logic            latch_req, load_instr, count_inc;
  logic            aligned;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      drop        <= 1'b0;
      req_pc      <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      fetch_count <= '0;
    end else begin
      state <= next_state;
      drop  <= drop_next;
      if (latch_req)  req_pc <= pc;
      if (load_instr) begin
        instr    <= imem_rsp_data;
        instr_pc <= req_pc;
      end
      if (count_inc)  fetch_count <= fetch_count + 32'd1;
    end
  end

  always_comb begin
    next_state     = state;
    drop_next      = drop;
    latch_req      = 1'b0;
    load_instr     = 1'b0;
    count_inc      = 1'b0;
    pc_en          = 1'b0;
    imem_req_valid = 1'b0;
    imem_req_addr  = '0;
    instr_valid    = 1'b0;
    misaligned     = 1'b0;
    aligned        = (pc[1:0] & FETCH_ALIGN_MASK) == 2'b00;

    case (state)
      IDLE: next_state = REQ;
      REQ: begin
        pc_en = flush;
        if (aligned) begin
          imem_req_valid = 1'b1;
          imem_req_addr  = pc;
          if (imem_req_ready) begin
            // A request accepted under flush is still owed a response; mark it for discard.
            latch_req  = 1'b1;
            drop_next  = flush;
            next_state = WAIT;
          end
        end else if (!flush) begin
          next_state = ERR;
        end
      end
      WAIT: begin
        if (flush) begin
          pc_en = 1'b1;
          if (imem_rsp_valid) begin
            drop_next  = 1'b0;
            next_state = REQ;
          end else begin
            drop_next = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (drop) begin
            drop_next  = 1'b0;
            next_state = REQ;
          end else begin
            load_instr = 1'b1;
            next_state = HOLD;
          end
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (flush) begin
          pc_en      = 1'b1;
          next_state = REQ;
        end else if (instr_ready) begin
          pc_en      = 1'b1;
          count_inc  = 1'b1;
          next_state = REQ;
        end
      end
      ERR: begin
        misaligned = 1'b1;
        if (flush) begin
          pc_en      = 1'b1;
          next_state = REQ;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a
// randomized run against a transaction-level memory/decode model.
module tb_instruction_fetch;
  localparam int XLEN = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic [XLEN-1:0] pc;
  logic            pc_en;
  logic            flush;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            instr_valid;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_ready;
  logic            misaligned;
  logic [31:0]     fetch_count;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  instruction_fetch #(.XLEN(XLEN)) dut (
    .clock          (clock),
    .reset          (reset),
    .pc             (pc),
    .pc_en          (pc_en),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .misaligned     (misaligned),
    .fetch_count    (fetch_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Outputs are sampled on the falling edge; inputs change 1 unit after the rising edge.
  task automatic settle();
    @(negedge clock);
  endtask

  // Advance one clock; the modelled program counter steps by 4 on each pc_en pulse.
  task automatic adv();
    logic pe;
    pe = pc_en;
    @(posedge clock);
    #1;
    if (pe) pc = pc + 32'd4;
  endtask

  // Stimulus only: from REQ, complete a handshake and a 1-cycle response into HOLD.
  task automatic to_hold(input logic [31:0] data);
    imem_req_ready = 1'b1;
    settle(); adv();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    settle(); adv();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0; pc = 32'h40; flush = 1'b1;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hFFFF_FFFF; instr_ready = 1'b1;
    settle();
    tests++; if (pc_en !== 1'b0) begin fails++; $display("FAIL reset_pc_en: got %b want 0", pc_en); end
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    tests++; if (imem_req_addr !== 32'h0) begin fails++; $display("FAIL reset_req_addr: got %h want 0", imem_req_addr); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
    tests++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin fails++; $display("FAIL reset_instr: got %h/%h want 0/0", instr, instr_pc); end
    tests++; if (misaligned !== 1'b0) begin fails++; $display("FAIL reset_misaligned: got %b want 0", misaligned); end
    tests++; if (fetch_count !== 32'h0) begin fails++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
    pc = '0; flush = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; instr_ready = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  task automatic test_basic();
    imem_req_ready = 1'b1;
    settle();
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL basic_idle_req: got %b want 0", imem_req_valid); end
    adv();
    settle();
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin fails++; $display("FAIL basic_req: got %b/%h want 1/0", imem_req_valid, imem_req_addr); end
    adv();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
    settle();
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL basic_wait_valid: got %b want 0", instr_valid); end
    adv();
    imem_rsp_valid = 1'b0; instr_ready = 1'b1;
    settle();
    tests++; if (instr_valid !== 1'b1 || instr !== 32'h13 || instr_pc !== 32'h0) begin fails++; $display("FAIL basic_hold: got %b/%h/%h want 1/00000013/0", instr_valid, instr, instr_pc); end
    tests++; if (pc_en !== 1'b1) begin fails++; $display("FAIL basic_pc_en: got %b want 1", pc_en); end
    adv();
    instr_ready = 1'b0;
    settle();
    tests++; if (pc_en !== 1'b0) begin fails++; $display("FAIL basic_pc_en_after: got %b want 0", pc_en); end
    tests++; if (fetch_count !== 32'd1) begin fails++; $display("FAIL basic_count: got %0d want 1", fetch_count); end
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin fails++; $display("FAIL basic_next_req: got %b/%h want 1/4", imem_req_valid, imem_req_addr); end
    adv();
  endtask

  task automatic test_req_stall();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4 || pc_en !== 1'b0) begin fails++; $display("FAIL req_stall_%0d: got valid %b addr %h pc_en %b want 1/4/0", i, imem_req_valid, imem_req_addr, pc_en); end
      adv();
    end
    to_hold(32'h0000_000A);
    instr_ready = 1'b1;
    settle();
    tests++; if (instr !== 32'hA || instr_pc !== 32'h4 || pc_en !== 1'b1) begin fails++; $display("FAIL req_stall_hold: got %h/%h pc_en %b want 0000000a/4/1", instr, instr_pc, pc_en); end
    adv();
    instr_ready = 1'b0;
    settle();
    tests++; if (imem_req_addr !== 32'h8 || fetch_count !== 32'd2) begin fails++; $display("FAIL req_stall_next: got addr %h count %0d want 8/2", imem_req_addr, fetch_count); end
    adv();
  endtask

  task automatic test_hold_stall();
    to_hold(32'h1234_5678);
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      tests++; if (instr_valid !== 1'b1 || instr !== 32'h1234_5678 || instr_pc !== 32'h8 || pc_en !== 1'b0) begin fails++; $display("FAIL hold_stall_%0d: got %b/%h/%h pc_en %b want 1/12345678/8/0", i, instr_valid, instr, instr_pc, pc_en); end
      adv();
    end
    instr_ready = 1'b1;
    settle();
    tests++; if (pc_en !== 1'b1) begin fails++; $display("FAIL hold_accept_pc_en: got %b want 1", pc_en); end
    adv();
    instr_ready = 1'b0;
    settle();
    tests++; if (fetch_count !== 32'd3 || imem_req_addr !== 32'hC || instr_valid !== 1'b0) begin fails++; $display("FAIL hold_next: got count %0d addr %h valid %b want 3/c/0", fetch_count, imem_req_addr, instr_valid); end
    adv();
  endtask

  task automatic test_flush_wait();
    imem_req_ready = 1'b1;
    settle(); adv();
    imem_req_ready = 1'b0; flush = 1'b1;
    settle();
    tests++; if (pc_en !== 1'b1) begin fails++; $display("FAIL flush_wait_pc_en: got %b want 1", pc_en); end
    adv();
    pc = 32'h100; flush = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    settle();
    tests++; if (instr_valid !== 1'b0 || pc_en !== 1'b0) begin fails++; $display("FAIL flush_wait_drop: got valid %b pc_en %b want 0/0", instr_valid, pc_en); end
    adv();
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    settle();
    tests++; if (instr_valid !== 1'b0 || pc_en !== 1'b0) begin fails++; $display("FAIL flush_wait_after: got valid %b pc_en %b want 0/0", instr_valid, pc_en); end
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100 || fetch_count !== 32'd3) begin fails++; $display("FAIL flush_wait_redirect: got %b/%h count %0d want 1/100/3", imem_req_valid, imem_req_addr, fetch_count); end
    adv();
  endtask

  task automatic test_flush_hold();
    to_hold(32'h0000_0055);
    flush = 1'b1; instr_ready = 1'b1;
    settle();
    tests++; if (pc_en !== 1'b1 || instr_valid !== 1'b1) begin fails++; $display("FAIL flush_hold: got pc_en %b valid %b want 1/1", pc_en, instr_valid); end
    adv();
    pc = 32'h200; flush = 1'b0; instr_ready = 1'b0;
    settle();
    tests++; if (instr_valid !== 1'b0 || pc_en !== 1'b0 || fetch_count !== 32'd3) begin fails++; $display("FAIL flush_hold_after: got valid %b pc_en %b count %0d want 0/0/3", instr_valid, pc_en, fetch_count); end
    tests++; if (imem_req_addr !== 32'h200) begin fails++; $display("FAIL flush_hold_addr: got %h want 200", imem_req_addr); end
    adv();
  endtask

  task automatic test_misaligned();
    pc = 32'h6; imem_req_ready = 1'b1;
    settle();
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL misalign_req: got %b want 0", imem_req_valid); end
    adv();
    for (int i = 0; i < 2; i++) begin
      settle();
      tests++; if (misaligned !== 1'b1 || imem_req_valid !== 1'b0 || pc_en !== 1'b0) begin fails++; $display("FAIL misalign_err_%0d: got mis %b valid %b pc_en %b want 1/0/0", i, misaligned, imem_req_valid, pc_en); end
      adv();
    end
    imem_req_ready = 1'b0; flush = 1'b1;
    settle();
    tests++; if (pc_en !== 1'b1) begin fails++; $display("FAIL misalign_flush_pc_en: got %b want 1", pc_en); end
    adv();
    pc = 32'h8; flush = 1'b0;
    settle();
    tests++; if (misaligned !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin fails++; $display("FAIL misalign_recover: got mis %b %b/%h want 0 1/8", misaligned, imem_req_valid, imem_req_addr); end
    adv();
  endtask

  // Model: fetches proceed in order from pc=8, each word is mem_word(address),
  // at most one request in flight until decode accepts the result.
  task automatic test_random();
    logic [31:0] exp_pc, exp_count, rsp_addr;
    logic        busy, pending, have_instr, rsp_now, accept;
    int          wait_cnt;
    exp_pc = 32'h8; exp_count = 32'd3; busy = 1'b0; pending = 1'b0; have_instr = 1'b0;
    wait_cnt = 0; rsp_addr = '0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      imem_req_ready = ($urandom_range(0, 2) != 0);
      instr_ready    = ($urandom_range(0, 3) != 0);
      rsp_now        = pending && (wait_cnt == 1);
      if (pending && !rsp_now) wait_cnt--;
      imem_rsp_valid = rsp_now;
      imem_rsp_data  = rsp_now ? mem_word(rsp_addr) : $urandom;
      settle();
      tests++; if (instr_valid !== have_instr) begin fails++; $display("FAIL rand_valid@%0d: got %b want %b", cyc, instr_valid, have_instr); end
      tests++; if (imem_req_valid !== !busy) begin fails++; $display("FAIL rand_req_valid@%0d: got %b want %b", cyc, imem_req_valid, !busy); end
      if (!busy) begin
        tests++; if (imem_req_addr !== exp_pc) begin fails++; $display("FAIL rand_addr@%0d: got %h want %h", cyc, imem_req_addr, exp_pc); end
      end
      tests++; if (pc_en !== (have_instr && instr_ready)) begin fails++; $display("FAIL rand_pc_en@%0d: got %b want %b", cyc, pc_en, have_instr && instr_ready); end
      if (have_instr) begin
        tests++; if (instr !== mem_word(exp_pc) || instr_pc !== exp_pc) begin fails++; $display("FAIL rand_instr@%0d: got %h/%h want %h/%h", cyc, instr, instr_pc, mem_word(exp_pc), exp_pc); end
      end
      tests++; if (fetch_count !== exp_count) begin fails++; $display("FAIL rand_count@%0d: got %0d want %0d", cyc, fetch_count, exp_count); end
      accept = have_instr && instr_ready;
      if (!busy && imem_req_ready) begin
        busy = 1'b1; pending = 1'b1; wait_cnt = $urandom_range(1, 3); rsp_addr = exp_pc;
      end
      if (accept) begin
        have_instr = 1'b0; busy = 1'b0; exp_pc = exp_pc + 32'd4; exp_count = exp_count + 32'd1;
      end
      if (rsp_now) begin
        pending = 1'b0; have_instr = 1'b1;
      end
      adv();
    end
  endtask

  task automatic test_reset_midflight();
    reset = 1'b0;
    #2;
    tests++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0 || pc_en !== 1'b0 || misaligned !== 1'b0) begin fails++; $display("FAIL mid_reset_ctrl: got %b%b%b%b want 0000", instr_valid, imem_req_valid, pc_en, misaligned); end
    tests++; if (fetch_count !== 32'h0 || instr !== 32'h0 || instr_pc !== 32'h0) begin fails++; $display("FAIL mid_reset_data: got %0d/%h/%h want 0/0/0", fetch_count, instr, instr_pc); end
    imem_req_ready = 1'b0; instr_ready = 1'b0; imem_rsp_valid = 1'b0; flush = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1; pc = 32'h300;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0BAD;
    settle();
    tests++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin fails++; $display("FAIL mid_reset_idle: got req %b valid %b want 0/0", imem_req_valid, instr_valid); end
    adv();
    imem_rsp_valid = 1'b0;
    settle();
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300 || instr_valid !== 1'b0) begin fails++; $display("FAIL mid_reset_req: got %b/%h valid %b want 1/300/0", imem_req_valid, imem_req_addr, instr_valid); end
    adv();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_req_stall();
    test_hold_stall();
    test_flush_wait();
    test_flush_hold();
    test_misaligned();
    test_random();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage sitting between the program counter and decode. Reads the current PC, issues one instruction-memory read per instruction over a valid/ready request channel, and buffers the returned word. It presents the word to decode with its PC and pulses `pc_en` back to the program counter when decode accepts it or when a redirect flushes the stage. Only one request is outstanding at a time.

## Interface
Parameters:
- `XLEN`, 32: address/data width.

Ports:
- `clock`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-low
- `pc`  in  XLEN  current PC from program counter
- `pc_en`  out  1  single-cycle pulse; program counter loads next PC at this edge
- `flush`  in  1  redirect; discard any buffered or in-flight instruction
- `imem_req_valid`  out  1  read request valid
- `imem_req_addr`  out  XLEN  read address
- `imem_req_ready`  in  1  memory accepts request
- `imem_rsp_valid`  in  1  read data valid; exactly one response per accepted request, earliest the cycle after acceptance
- `imem_rsp_data`  in  XLEN  read data
- `instr_valid`  out  1  buffered instruction valid
- `instr`  out  XLEN  buffered instruction
- `instr_pc`  out  XLEN  PC of buffered instruction
- `instr_ready`  in  1  decode accepts instruction
- `misaligned`  out  1  PC not word aligned; fetch halted
- `fetch_count`  out  32  instructions accepted by decode since reset

## Operation
States:
- IDLE: reset state; all outputs 0; unconditionally → REQ next cycle.
- REQ: if `pc[1:0]!=0`, then `imem_req_valid=0` and → ERR. Otherwise `imem_req_valid=1`, `imem_req_addr=pc`. On `valid&ready`, latch `pc` into the request-PC register and → WAIT. Otherwise stay.
- WAIT: on `imem_rsp_valid`:
  - If the drop flag is set, discard the response, clear drop, → REQ.
  - Otherwise load `instr`←data and `instr_pc`←request-PC, → HOLD.
- HOLD: `instr_valid=1`. On `instr_ready`, `pc_en=1`, `fetch_count`+1, → REQ.
- ERR: `misaligned=1`; no requests. Leaves only on `flush`: `pc_en=1`, → REQ.

Flush (highest priority, every state except IDLE):
- `pc_en=1` for that cycle.
- REQ: if the handshake completes the same cycle, → WAIT with drop set. Otherwise stay in REQ.
- WAIT: set drop. If `imem_rsp_valid` arrives the same cycle, discard it and → REQ.
- HOLD: `instr_valid` drops next cycle, → REQ, no count increment. `pc_en` is a single pulse even if `instr_ready` is also high.
- ERR: → REQ, `misaligned` clears next cycle.

Other rules:
- `pc_en = (HOLD & instr_ready) | (flush & state!=IDLE)`.
- `fetch_count` is a 32-bit counter and wraps 0xFFFFFFFF→0.
- `instr` and `instr_pc` hold their value outside HOLD. They are don't-care when `instr_valid=0`.

## Timing
- Reset (async, active-low): state=IDLE, `instr`=0, `instr_pc`=0, `fetch_count`=0, drop=0. All outputs read 0 while reset is asserted.
- Minimum loop with a 1-cycle memory: REQ(handshake) → WAIT(rsp) → HOLD(accept) → REQ. That is 3 cycles per instruction.
- `instr_valid` rises the cycle after `imem_rsp_valid`.
- The new PC is visible on `pc` the cycle after `pc_en`, and REQ uses it that cycle.
- `imem_req_valid` stays high in REQ until `imem_req_ready`. `imem_req_addr` tracks `pc` while waiting; `pc` is stable because `pc_en` is low.
- Reset mid-transaction returns to IDLE. An in-flight response arriving after reset release is ignored, since responses are only sampled in WAIT.

## Structure
- Shared package `fetch_pkg`: `fetch_state_t` enum {IDLE, REQ, WAIT, HOLD, ERR}; constant `FETCH_ALIGN_MASK = 2'b11`.
- Single module with no sub-module.
- State register, drop flag, request-PC register, instruction buffer and counter are all in one `always_ff`. Outputs and next state are in one `always_comb`.

## Test plan
- Reset, `pc`=0, ready=1, rsp 1 cycle later with 0x00000013, `instr_ready`=1 → `instr`=0x13, `instr_pc`=0, one `pc_en` pulse, `fetch_count`=1, next request addr 4.
- `imem_req_ready` low for 3 cycles → `imem_req_valid` held high, addr constant, no `pc_en`; then proceeds normally.
- `instr_ready` low for 4 cycles in HOLD → `instr_valid` held, `instr` stable, `pc_en` only on the accept cycle.
- `flush` in WAIT, response next cycle with 0xDEADBEEF → response discarded, `instr_valid` never rises, one `pc_en`, new request at the redirected `pc`.
- `flush` and `instr_ready` together in HOLD → exactly one `pc_en`, `fetch_count` unchanged.
- `pc`=0x00000006 → no request, `misaligned`=1. Then `flush` with `pc`=8 → `misaligned` clears, request addr 8.
